// File: rtl/ram_banked_ctrl.sv
// Banked synchronous data RAM with a request/ready front end, byte enables,
// a registered one-cycle read port and an optional zero-fill after reset.
module ram_banked_ctrl #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int BANK_BITS      = 2,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    CLK,
    input  logic                    Rst,
    input  logic                    Req,
    input  logic                    R_W,
    input  logic [ADDR_WIDTH-1:0]   Addr,
    input  logic [DATA_WIDTH-1:0]   WData,
    input  logic [DATA_WIDTH/8-1:0] BE,
    output logic                    Ready,
    output logic [DATA_WIDTH-1:0]   RData,
    output logic                    RValid,
    output logic                    Init_Done,
    output logic                    state_dbg
);

    localparam int NB     = 1 << BANK_BITS;
    localparam int IDX_W  = ADDR_WIDTH - BANK_BITS;
    localparam int NBYTES = DATA_WIDTH / 8;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? INIT : IDLE;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               init_done_q;

    logic [BANK_BITS-1:0]  bank_sel;
    logic [IDX_W-1:0]      idx;
    logic                  accept;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] bank_rd [NB];

    assign bank_sel = Addr[ADDR_WIDTH-1 -: BANK_BITS];
    assign idx      = Addr[IDX_W-1:0];

    // Handshake: a request transfers on a rising edge where Req && Ready;
    // Ready depends only on state (and reset), never on Req, and nothing is queued.
    assign Ready  = (state_q == IDLE) && Rst;
    assign accept = Req && Ready;
    assign wr_en  = accept && !R_W;
    assign rd_en  = accept && R_W;

    assign state_dbg = state_q;
    assign Init_Done = init_done_q;

    always_ff @(posedge CLK or negedge Rst) begin
        if (!Rst) begin
            state_q     <= RST_STATE;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= (state_d == IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + IDX_W'(1);
                if (&cnt_q) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = RST_STATE;
            end
        endcase
    end

    // The clear writes the same index in every bank at once; afterwards only
    // the addressed bank sees a write strobe.
    for (genvar g = 0; g < NB; g++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [1 << IDX_W];
        logic                  bank_wr;

        assign bank_wr    = wr_en && (bank_sel == BANK_BITS'(g));
        assign bank_rd[g] = mem[idx];

        always_ff @(posedge CLK) begin
            if (state_q == INIT) begin
                mem[cnt_q] <= '0;
            end else if (bank_wr) begin
                for (int b = 0; b < NBYTES; b++) begin
                    if (BE[b]) begin
                        mem[idx][8*b +: 8] <= WData[8*b +: 8];
                    end
                end
            end
        end
    end

    // RData only moves on an accepted read, so writes never disturb it.
    always_ff @(posedge CLK or negedge Rst) begin
        if (!Rst) begin
            RData  <= '0;
            RValid <= 1'b0;
        end else begin
            RValid <= rd_en;
            if (rd_en) begin
                RData <= bank_rd[bank_sel];
            end
        end
    end

endmodule

// File: tb/tb_ram_banked_ctrl.sv
// Directed bench for ram_banked_ctrl: default build plus two small-parameter
// builds (no clear / with clear).
module tb_ram_banked_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic        rst_n, req, r_w;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ready, rvalid, init_done, state_dbg;
    logic [31:0] rdata;

    // small instances share their inputs
    logic        rst_s0, rst_s1, s_req, s_r_w;
    logic [7:0]  s_addr;
    logic [15:0] s_wdata;
    logic [1:0]  s_be;
    logic        s0_ready, s0_rvalid, s0_done, s0_state;
    logic        s1_ready, s1_rvalid, s1_done, s1_state;
    logic [15:0] s0_rdata, s1_rdata;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    ram_banked_ctrl dut (
        .CLK(clk), .Rst(rst_n), .Req(req), .R_W(r_w), .Addr(addr),
        .WData(wdata), .BE(be), .Ready(ready), .RData(rdata),
        .RValid(rvalid), .Init_Done(init_done), .state_dbg(state_dbg)
    );

    ram_banked_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .BANK_BITS(1), .CLEAR_ON_RESET(0)) dut_s0 (
        .CLK(clk), .Rst(rst_s0), .Req(s_req), .R_W(s_r_w), .Addr(s_addr),
        .WData(s_wdata), .BE(s_be), .Ready(s0_ready), .RData(s0_rdata),
        .RValid(s0_rvalid), .Init_Done(s0_done), .state_dbg(s0_state)
    );

    ram_banked_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .BANK_BITS(1), .CLEAR_ON_RESET(1)) dut_s1 (
        .CLK(clk), .Rst(rst_s1), .Req(s_req), .R_W(s_r_w), .Addr(s_addr),
        .WData(s_wdata), .BE(s_be), .Ready(s1_ready), .RData(s1_rdata),
        .RValid(s1_rvalid), .Init_Done(s1_done), .state_dbg(s1_state)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        req = 1'b1; r_w = 1'b0; addr = a; wdata = d; be = b;
        @(negedge clk);
        req = 1'b0;
        check_eq("wr_rvalid", 32'(rvalid), 32'd0);
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
        @(negedge clk);
        req = 1'b1; r_w = 1'b1; addr = a;
        @(negedge clk);
        req = 1'b0;
        check_eq({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        check_eq(tag, rdata, exp);
    endtask

    // Counts the cycles Ready stays low, bounded so a stuck clear still ends.
    task automatic count_clear(output int n, output bit saw_rv);
        n = 0;
        saw_rv = 1'b0;
        while (!ready && n < 3000) begin
            @(negedge clk);
            n++;
            if (rvalid) saw_rv = 1'b1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        bit saw;

        rst_n = 1'b0; req = 1'b0; r_w = 1'b0; addr = '0; wdata = '0; be = '0;
        rst_s0 = 1'b0; rst_s1 = 1'b0;
        s_req = 1'b0; s_r_w = 1'b0; s_addr = '0; s_wdata = '0; s_be = '0;
        repeat (3) @(negedge clk);

        check_eq("rst_ready", 32'(ready), 32'd0);
        check_eq("rst_rvalid", 32'(rvalid), 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        check_eq("rst_init_done", 32'(init_done), 32'd0);
        check_eq("rst_state", 32'(state_dbg), 32'd0);
        check_eq("s0_rst_ready", 32'(s0_ready), 32'd0);

        // reset pulse in the middle of the clear
        rst_n = 1'b1;
        repeat (500) @(negedge clk);
        check_eq("mid_clear_ready", 32'(ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_ready", 32'(ready), 32'd0);
        check_eq("mid_rst_rvalid", 32'(rvalid), 32'd0);
        check_eq("mid_rst_rdata", rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req = 1'b1; r_w = 1'b1; addr = 12'h123;
        count_clear(n, saw);
        req = 1'b0;
        check_eq("clear_len", 32'(n), 32'd1024);
        check_eq("clear_req_ignored", 32'(saw), 32'd0);
        check_eq("clear_init_done", 32'(init_done), 32'd1);
        check_eq("clear_state", 32'(state_dbg), 32'd1);

        rd(12'h000, 32'h0, "zero_000");
        rd(12'h3FF, 32'h0, "zero_3ff");
        rd(12'h400, 32'h0, "zero_400");
        rd(12'hFFF, 32'h0, "zero_fff");

        // bank isolation
        wr(12'h005, 32'hA5A5A5A5, 4'hF);
        wr(12'hC05, 32'h5A5A5A5A, 4'hF);
        rd(12'h005, 32'hA5A5A5A5, "bank_005");
        rd(12'h405, 32'h00000000, "bank_405");
        rd(12'hC05, 32'h5A5A5A5A, "bank_c05");

        // byte enables
        wr(12'h010, 32'h11223344, 4'b1111);
        wr(12'h010, 32'hAABBCCDD, 4'b0101);
        rd(12'h010, 32'h11BB33DD, "be_0101");
        wr(12'h010, 32'hFFFFFFFF, 4'b0000);
        rd(12'h010, 32'h11BB33DD, "be_0000");

        // back-to-back reads
        for (int i = 1; i <= 4; i++) wr(12'(i), 32'(i), 4'hF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check_eq("pipe_rvalid", 32'(rvalid), 32'd1);
                check_eq("pipe_rdata", rdata, exp_q.pop_front());
            end
            req = 1'b1; r_w = 1'b1; addr = 12'(i + 1);
            exp_q.push_back(32'(i + 1));
        end
        @(negedge clk);
        req = 1'b0;
        check_eq("pipe_rvalid", 32'(rvalid), 32'd1);
        check_eq("pipe_rdata", rdata, exp_q.pop_front());
        @(negedge clk);
        check_eq("pipe_rvalid_drop", 32'(rvalid), 32'd0);

        // write then read on consecutive edges
        @(negedge clk);
        req = 1'b1; r_w = 1'b0; addr = 12'h020; wdata = 32'hCAFEF00D; be = 4'hF;
        @(negedge clk);
        r_w = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check_eq("wr_rd_rvalid", 32'(rvalid), 32'd1);
        check_eq("wr_rd_rdata", rdata, 32'hCAFEF00D);

        // a write to the same word leaves RData alone
        @(negedge clk);
        req = 1'b1; r_w = 1'b0; addr = 12'h020; wdata = 32'h12345678; be = 4'hF;
        @(negedge clk);
        req = 1'b0;
        check_eq("hold_rdata", rdata, 32'hCAFEF00D);
        check_eq("hold_rvalid", 32'(rvalid), 32'd0);
        rd(12'h020, 32'h12345678, "hold_reread");

        // reset lands before the read's edge: the read never completes
        @(negedge clk);
        req = 1'b1; r_w = 1'b1; addr = 12'h005;
        #2 rst_n = 1'b0;
        #1;
        check_eq("flight_ready", 32'(ready), 32'd0);
        @(negedge clk);
        req = 1'b0;
        check_eq("flight_rvalid", 32'(rvalid), 32'd0);
        check_eq("flight_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        count_clear(n, saw);
        check_eq("clear2_len", 32'(n), 32'd1024);

        // reset right after the read's edge drops RValid at once
        wr(12'h005, 32'h0BADF00D, 4'hF);
        @(negedge clk);
        req = 1'b1; r_w = 1'b1; addr = 12'h005;
        @(posedge clk);
        #1;
        req = 1'b0;
        check_eq("late_rst_rvalid_pre", 32'(rvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("late_rst_rvalid", 32'(rvalid), 32'd0);
        check_eq("late_rst_rdata", rdata, 32'd0);

        // small build without clear
        @(negedge clk);
        rst_s0 = 1'b1;
        @(negedge clk);
        check_eq("s0_ready", 32'(s0_ready), 32'd1);
        check_eq("s0_init_done", 32'(s0_done), 32'd1);
        s_req = 1'b1; s_r_w = 1'b0; s_addr = 8'hFF; s_wdata = 16'hBEEF; s_be = 2'b11;
        @(negedge clk);
        s_r_w = 1'b1;
        @(negedge clk);
        s_req = 1'b0;
        check_eq("s0_rvalid", 32'(s0_rvalid), 32'd1);
        check_eq("s0_rdata", 32'(s0_rdata), 32'h0000BEEF);

        // small build with clear
        rst_s1 = 1'b1;
        n = 0;
        while (!s1_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq("s1_clear_len", 32'(n), 32'd128);
        check_eq("s1_init_done", 32'(s1_done), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_banked_ctrl.md
# ram_banked_ctrl

Parametrised, word-interleaved-free banked synchronous RAM with a request/ready front end, per-byte write enables, registered one-cycle read and hardware clear after reset. It replaces fixed 4K×32 chip-select arrays as the data memory behind the load/store unit. Separate read and write data buses replace the bidirectional bus.

## Interface
Parameters:
- ADDR_WIDTH, 12, word address width; total depth 2^ADDR_WIDTH words
- DATA_WIDTH, 32, word width; must be a multiple of 8
- BANK_BITS, 2, number of bank-select bits; 2^BANK_BITS banks, each 2^(ADDR_WIDTH-BANK_BITS) deep
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = skip clear

Ports:
- CLK  in  1  clock, all state on rising edge
- Rst  in  1  asynchronous, active-low reset
- Req  in  1  access request
- R_W  in  1  1 = read, 0 = write
- Addr  in  ADDR_WIDTH  word address; Addr[ADDR_WIDTH-1 -: BANK_BITS] selects bank, remainder is the in-bank index
- WData  in  DATA_WIDTH  write data
- BE  in  DATA_WIDTH/8  byte enables; BE[i] gates WData[8i+7:8i]
- Ready  out  1  block accepts a request this cycle
- RData  out  DATA_WIDTH  read data
- RValid  out  1  RData carries the result of the read accepted on the previous edge
- Init_Done  out  1  clear sequence finished

## Operation
- FSM states: INIT, IDLE.
- Rst low: FSM → INIT if CLEAR_ON_RESET=1, else IDLE. Clear counter = 0; Ready = 0; RValid = 0; RData = 0; Init_Done = 0. Memory contents are not touched asynchronously.
- INIT: each cycle writes 0 to index `cnt` in all banks in parallel, then increments `cnt`. After index 2^(ADDR_WIDTH-BANK_BITS)-1 is written → IDLE, with Init_Done = 1. Req is ignored in INIT.
- IDLE: Ready = 1 combinationally from state. A request is accepted on an edge where Req & Ready.
- Accepted write: for each i with BE[i]=1, byte i of the addressed word ← WData byte i. Other bytes are unchanged. BE = 0 is a legal no-op write. RValid = 0 on the next cycle.
- Accepted read: RData ← word at Addr on the same edge. RValid = 1 for exactly the following cycle unless another read is accepted.
- RData holds its last read value until the next accepted read. Writes never modify RData, including writes to the same address.
- Only one access per cycle; no read-during-write case exists.
- Only the selected bank is enabled on an access. Unselected banks hold their contents.
- CLEAR_ON_RESET=0: Init_Done = 1 from the first edge after Rst rises. Contents are undefined until written.

## Timing
- Clear duration: 2^(ADDR_WIDTH-BANK_BITS) cycles (1024 with defaults). Ready first samples 1 on the cycle after the last clear write.
- Read latency: 1 cycle. Read accepted at edge N → RData/RValid valid in the cycle after N.
- Throughput: one access per cycle. Back-to-back reads give RValid continuously high.
- Write at edge N followed by a read of the same address at edge N+1 returns the new data.
- Rst asserted mid-INIT: the clear restarts from index 0 after release.
- Rst asserted in IDLE with a read in flight: RValid drops to 0 immediately (asynchronously); the result is lost.
- Req held high while Ready = 0: no side effects. Req is not queued.

## Test plan
- Reset/clear: release Rst with defaults → Ready = 0 for exactly 1024 cycles, then Ready = 1 and Init_Done = 1. Read addresses 0x000, 0x3FF, 0x400 and 0xFFF → all return 0x00000000.
- Bank isolation: write 0xA5A5A5A5 to 0x005 and 0x5A5A5A5A to 0xC05 → read 0x005 = 0xA5A5A5A5, 0x405 = 0, 0xC05 = 0x5A5A5A5A.
- Byte enables: write 0x11223344 with BE = 1111, then 0xAABBCCDD with BE = 0101 to 0x010 → read returns 0x11BB33DD. A BE = 0000 write leaves 0x11BB33DD.
- Pipelining: 4 back-to-back reads of 0x001–0x004 preloaded with 1–4 → RValid high for 4 consecutive cycles, RData = 1, 2, 3, 4. A write then a read of 0x020 on consecutive edges returns the written value.
- Reset mid-operation: pulse Rst low at clear count 500 → RData = 0, RValid = 0 and Ready = 0 immediately; after release the full 1024-cycle clear restarts. Pulse Rst during an in-flight read → RValid never asserts.
- Parameter sweep: ADDR_WIDTH = 8, DATA_WIDTH = 16, BANK_BITS = 1, CLEAR_ON_RESET = 0 → Ready = 1 on the first cycle after reset release; write/read 0xBEEF at 0xFF round-trips; clear-enabled variant takes 128 cycles.
